// File: rtl/invaders_pkg.sv
// Types and default geometry shared by the enemy-fire scheduler and the bullet movers.
// Bullet launch offsets are relative to the bottom alien's top-left corner.
package invaders_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    S_COOL,
    S_ARB,
    S_LAUNCH
  } sched_state_t;

  localparam int X_OFF    = 6;
  localparam int Y_OFF    = 16;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set bit of req at or above ptr, wrapping.
// Zero latency; gnt_valid low when req is empty.
module rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alien_fire_scheduler.sv
// Picks a firing alien column (round-robin) and a free bullet mover, with a frame cooldown.
// Spawn strobe one cycle after the arbitration decision; stalls in arbitration while all movers are busy.
module alien_fire_scheduler #(
  parameter  int NUM_COLS  = 8,
  parameter  int NUM_SLOTS = 3,
  parameter  int COOLDOWN  = 30,
  parameter  int X_OFF     = invaders_pkg::X_OFF,
  parameter  int Y_OFF     = invaders_pkg::Y_OFF,
  localparam int CW        = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   enable,
  input  logic [NUM_COLS-1:0]    fire_req,
  input  logic [NUM_COLS*10-1:0] col_X,
  input  logic [NUM_COLS*10-1:0] col_Y,
  input  logic [NUM_SLOTS-1:0]   slot_done,
  output logic [NUM_SLOTS-1:0]   spawn,
  output logic [9:0]             spawn_X,
  output logic [9:0]             spawn_Y,
  output logic [NUM_SLOTS-1:0]   slot_busy,
  output logic [CW-1:0]          grant_col
);

  import invaders_pkg::*;

  localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CCW = $clog2(COOLDOWN + 1);
  localparam logic [CCW-1:0] COOL_RELOAD = CCW'(COOLDOWN);

  sched_state_t         state, state_nxt;
  logic [CCW-1:0]       cool_cnt;
  logic [CW-1:0]        rr_ptr, pend_col, col_idx;
  logic [SW-1:0]        pend_slot, slot_idx;
  coord_t               pend_X, pend_Y, sel_X, sel_Y;
  logic                 col_vld, slot_vld, launch_ok;
  logic [NUM_SLOTS-1:0] free_slots, busy_nxt, launch_mask;

  assign free_slots = ~slot_busy;
  assign launch_ok  = col_vld && slot_vld;

  rr_arbiter #(.N(NUM_COLS)) u_col_arb (
    .req       (fire_req),
    .ptr       (rr_ptr),
    .gnt_valid (col_vld),
    .gnt_idx   (col_idx)
  );

  // Same picker with the pointer pinned at 0 gives lowest-index free slot.
  rr_arbiter #(.N(NUM_SLOTS)) u_slot_arb (
    .req       (free_slots),
    .ptr       ('0),
    .gnt_valid (slot_vld),
    .gnt_idx   (slot_idx)
  );

  assign sel_X = col_X[10*col_idx +: 10] + coord_t'(X_OFF);
  assign sel_Y = col_Y[10*col_idx +: 10] + coord_t'(Y_OFF);

  always_comb begin
    launch_mask            = '0;
    launch_mask[pend_slot] = 1'b1;
  end

  // A launch set beats a done clear on the same slot.
  always_comb begin
    busy_nxt = slot_busy & ~slot_done;
    if (state == S_LAUNCH) busy_nxt = busy_nxt | launch_mask;
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) state <= S_COOL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_COOL:   if (enable && cool_cnt == '0) state_nxt = S_ARB;
      S_ARB: begin
        if (!enable)        state_nxt = S_COOL;
        else if (launch_ok) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: state_nxt = S_COOL;
      default:  state_nxt = S_COOL;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      cool_cnt  <= COOL_RELOAD;
      rr_ptr    <= '0;
      pend_col  <= '0;
      pend_slot <= '0;
      pend_X    <= '0;
      pend_Y    <= '0;
      spawn     <= '0;
      spawn_X   <= '0;
      spawn_Y   <= '0;
      slot_busy <= '0;
      grant_col <= '0;
    end else begin
      spawn     <= '0;
      slot_busy <= busy_nxt;
      case (state)
        S_COOL: begin
          if (enable && cool_cnt != '0) cool_cnt <= cool_cnt - 1'b1;
        end
        S_ARB: begin
          if (!enable) begin
            cool_cnt <= COOL_RELOAD;
          end else if (launch_ok) begin
            pend_col  <= col_idx;
            pend_slot <= slot_idx;
            pend_X    <= sel_X;
            pend_Y    <= sel_Y;
          end
        end
        S_LAUNCH: begin
          spawn     <= launch_mask;
          spawn_X   <= pend_X;
          spawn_Y   <= pend_Y;
          grant_col <= pend_col;
          rr_ptr    <= (pend_col == CW'(NUM_COLS - 1)) ? '0 : pend_col + 1'b1;
          cool_cnt  <= COOL_RELOAD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Directed bench for alien_fire_scheduler: launch timing, arbitration order, pausing and reset.
module tb_alien_fire_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        enable;
  logic [7:0]  fire_req;
  logic [79:0] col_X;
  logic [79:0] col_Y;
  logic [2:0]  slot_done;
  logic [2:0]  spawn;
  logic [9:0]  spawn_X;
  logic [9:0]  spawn_Y;
  logic [2:0]  slot_busy;
  logic [2:0]  grant_col;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  int mark   = 0;
  int n;

  alien_fire_scheduler dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (enable),
    .fire_req  (fire_req),
    .col_X     (col_X),
    .col_Y     (col_Y),
    .slot_done (slot_done),
    .spawn     (spawn),
    .spawn_X   (spawn_X),
    .spawn_Y   (spawn_Y),
    .slot_busy (slot_busy),
    .grant_col (grant_col)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge; returns at the following falling edge where outputs are sampled.
  task automatic step();
    @(posedge frame_clk);
    @(negedge frame_clk);
    ecount++;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    mark  = ecount;
  endtask

  // Steps at least once, then until spawn is seen or the budget runs out.
  task automatic wait_spawn(input int bound);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (spawn == 3'b000 && k < bound);
  endtask

  task automatic set_col(input int c, input int x, input int y);
    col_X[10*c +: 10] = 10'(x);
    col_Y[10*c +: 10] = 10'(y);
  endtask

  task automatic pulse_done(input logic [2:0] m);
    slot_done = m;
    step();
    slot_done = 3'b000;
  endtask

  initial begin
    Reset     = 1'b0;
    enable    = 1'b0;
    fire_req  = '0;
    col_X     = '0;
    col_Y     = '0;
    slot_done = '0;
    @(negedge frame_clk);

    // Reset values, then first launch from column 4.
    set_col(4, 200, 100);
    do_reset();
    check("rst_spawn", spawn, 3'b000);
    check("rst_spawn_x", spawn_X, 10'd0);
    check("rst_spawn_y", spawn_Y, 10'd0);
    check("rst_busy", slot_busy, 3'b000);
    check("rst_grant", grant_col, 3'd0);
    enable   = 1'b1;
    fire_req = 8'h10;
    n = 0;
    for (int i = 0; i < 29; i++) begin
      step();
      if (spawn != 3'b000) n++;
    end
    check("early_spawn", n, 0);
    wait_spawn(20);
    check("t1_edge", ecount - mark, 33);
    check("t1_spawn", spawn, 3'b001);
    check("t1_x", spawn_X, 10'd206);
    check("t1_y", spawn_Y, 10'd116);
    check("t1_grant", grant_col, 3'd4);
    check("t1_busy", slot_busy, 3'b001);
    step();
    check("t1_pulse_end", spawn, 3'b000);
    check("t1_x_hold", spawn_X, 10'd206);

    // All columns requesting: columns 0,1,2 into slots 0,1,2, then stall.
    for (int c = 0; c < 8; c++) set_col(c, 16*c + 50, 20 + c);
    fire_req = 8'hFF;
    do_reset();
    wait_spawn(40);
    check("t2_l0_edge", ecount - mark, 33);
    check("t2_l0_slot", spawn, 3'b001);
    check("t2_l0_col", grant_col, 3'd0);
    wait_spawn(40);
    check("t2_l1_edge", ecount - mark, 66);
    check("t2_l1_slot", spawn, 3'b010);
    check("t2_l1_col", grant_col, 3'd1);
    check("t2_l1_x", spawn_X, 10'd72);
    wait_spawn(40);
    check("t2_l2_edge", ecount - mark, 99);
    check("t2_l2_slot", spawn, 3'b100);
    check("t2_l2_col", grant_col, 3'd2);
    check("t2_full", slot_busy, 3'b111);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (spawn != 3'b000) n++;
    end
    check("t2_stall_nospawn", n, 0);
    pulse_done(3'b010);
    check("t2_freed", slot_busy, 3'b101);
    mark = ecount;
    wait_spawn(10);
    check("t2_relaunch_lat", ecount - mark, 2);
    check("t2_relaunch_slot", spawn, 3'b010);
    check("t2_relaunch_col", grant_col, 3'd3);
    check("t2_relaunch_x", spawn_X, 10'd104);
    check("t2_relaunch_y", spawn_Y, 10'd39);
    check("t2_refull", slot_busy, 3'b111);

    // Round-robin wrap from pointer 6, coordinate wrap, done-pulse handling.
    set_col(5, 300, 200);
    set_col(0, 1020, 1015);
    set_col(2, 40, 60);
    fire_req = 8'h20;
    do_reset();
    wait_spawn(40);
    check("t3_l0_col", grant_col, 3'd5);
    check("t3_l0_x", spawn_X, 10'd306);
    fire_req = 8'h05;
    pulse_done(3'b100);
    check("t3_idle_done", slot_busy, 3'b001);
    wait_spawn(40);
    check("t3_l1_edge", ecount - mark, 66);
    check("t3_l1_col", grant_col, 3'd0);
    check("t3_l1_slot", spawn, 3'b010);
    check("t3_l1_xwrap", spawn_X, 10'd2);
    check("t3_l1_ywrap", spawn_Y, 10'd7);
    wait_spawn(40);
    check("t3_l2_edge", ecount - mark, 99);
    check("t3_l2_col", grant_col, 3'd2);
    check("t3_l2_slot", spawn, 3'b100);
    check("t3_l2_busy", slot_busy, 3'b111);
    pulse_done(3'b011);
    check("t3_dual_done", slot_busy, 3'b100);

    // Pause for 10 frames while cool_cnt is 12: launch slips by exactly 10.
    fire_req = 8'h01;
    enable   = 1'b1;
    do_reset();
    for (int i = 0; i < 18; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    enable = 1'b1;
    wait_spawn(60);
    check("t4_pause_edge", ecount - mark, 43);
    check("t4_pause_slot", spawn, 3'b001);

    // Drop enable while waiting in arbitration: full cooldown, no launch.
    fire_req = 8'h00;
    do_reset();
    for (int i = 0; i < 35; i++) step();
    enable   = 1'b0;
    fire_req = 8'h01;
    step();
    check("t4_arb_drop_nospawn", spawn, 3'b000);
    mark   = ecount;
    enable = 1'b1;
    wait_spawn(60);
    check("t4_arb_drop_edge", ecount - mark, 33);
    check("t4_arb_drop_col", grant_col, 3'd0);

    // Reset landing on the launch cycle swallows the launch.
    do_reset();
    for (int i = 0; i < 32; i++) step();
    check("t5_pre_launch", spawn, 3'b000);
    Reset = 1'b0;
    step();
    check("t5_rst_spawn", spawn, 3'b000);
    check("t5_rst_busy", slot_busy, 3'b000);
    Reset = 1'b1;
    mark  = ecount;
    wait_spawn(60);
    check("t5_restart_edge", ecount - mark, 33);
    check("t5_restart_slot", spawn, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
